// File: rtl/ddr_arb_pkg.sv
// Shared command encodings, burst length and FSM state type for the DDR request arbiter.
package ddr_arb_pkg;
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam int BEATS_PER_BURST = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WDATA
  } state_t;
endpackage

// File: rtl/ddr_tag_fifo.sv
// In-order queue of client tags for outstanding reads; head tag routes returning rdf beats.
module ddr_tag_fifo
  import ddr_arb_pkg::*;
#(
  parameter int TAG_W = 2,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [TAG_W-1:0] push_tag,
  input  logic             pop,
  output logic [TAG_W-1:0] head_tag,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push, do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & !full;
  assign do_pop   = pop & !empty;
  assign head_tag = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end
endmodule

// File: rtl/ddr_request_arbiter.sv
// N-client round-robin arbiter onto the DDR2 af/wdf FIFOs with in-order rdf return routing.
// Optional ARB_FIXED_PRIO_EN: client 0 wins arbitration whenever eligible.
module ddr_request_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_W      = 31,
  parameter int DATA_W      = 128,
  parameter int MASK_W      = 16,
  parameter int TAG_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_CLIENTS-1:0]        cl_req_valid,
  output logic [NUM_CLIENTS-1:0]        cl_req_ready,
  input  logic [3*NUM_CLIENTS-1:0]      cl_req_cmd,
  input  logic [ADDR_W*NUM_CLIENTS-1:0] cl_req_addr,
  input  logic [NUM_CLIENTS-1:0]        cl_wdf_valid,
  output logic [NUM_CLIENTS-1:0]        cl_wdf_ready,
  input  logic [DATA_W*NUM_CLIENTS-1:0] cl_wdf_din,
  input  logic [MASK_W*NUM_CLIENTS-1:0] cl_wdf_mask,
  output logic [NUM_CLIENTS-1:0]        cl_rdf_valid,
  input  logic [NUM_CLIENTS-1:0]        cl_rdf_rd_en,
  input  logic                          af_full,
  output logic                          af_wr_en,
  output logic [2:0]                    af_cmd_din,
  output logic [ADDR_W-1:0]             af_addr_din,
  input  logic                          wdf_full,
  output logic                          wdf_wr_en,
  output logic [DATA_W-1:0]             wdf_din,
  output logic [MASK_W-1:0]             wdf_mask_din,
  input  logic                          rdf_valid,
  output logic                          rdf_rd_en,
  output logic                          err_orphan
);
  localparam int   IDX_W     = $clog2(NUM_CLIENTS);
  localparam logic BEAT_LAST = 1'(BEATS_PER_BURST - 1);

  state_t           state, next_state;
  logic [IDX_W-1:0] grant, rr_ptr, pick, head, next_rr;
  logic [IDX_W:0]   idx;
  logic [NUM_CLIENTS-1:0] eligible;
  logic found, grant_is_read, adv_rr, rr_hold;
  logic wbeat, rbeat;
  logic tag_push, tag_pop, tag_full, tag_empty;

  ddr_tag_fifo #(.TAG_W(IDX_W), .DEPTH(TAG_DEPTH)) u_tags (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_push),
    .push_tag (grant),
    .pop      (tag_pop),
    .head_tag (head),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  // cmd[0] alone decides read vs write, so illegal encodings fold into one of the two.
  always_comb begin
    eligible = '0;
    found    = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      eligible[i] = cl_req_valid[i] & (!cl_req_cmd[3*i] | !tag_full);
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (idx >= (IDX_W+1)'(NUM_CLIENTS)) idx = idx - (IDX_W+1)'(NUM_CLIENTS);
      if (!found && eligible[idx[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDX_W-1:0];
      end
    end
`ifdef ARB_FIXED_PRIO_EN
    if (eligible[0]) begin
      found = 1'b1;
      pick  = '0;
    end
`endif
  end

`ifdef ARB_FIXED_PRIO_EN
  assign rr_hold = (grant == '0);
`else
  assign rr_hold = 1'b0;
`endif

  assign grant_is_read = cl_req_cmd[3*int'(grant)];
  assign next_rr       = (grant == IDX_W'(NUM_CLIENTS-1)) ? '0 : grant + 1'b1;

  always_comb begin
    next_state   = state;
    af_wr_en     = 1'b0;
    af_cmd_din   = '0;
    af_addr_din  = '0;
    cl_req_ready = '0;
    cl_wdf_ready = '0;
    wdf_wr_en    = 1'b0;
    wdf_din      = '0;
    wdf_mask_din = '0;
    tag_push     = 1'b0;
    adv_rr       = 1'b0;
    case (state)
      IDLE: if (found) next_state = ISSUE;
      ISSUE: begin
        af_cmd_din  = cl_req_cmd[3*int'(grant) +: 3];
        af_addr_din = cl_req_addr[ADDR_W*int'(grant) +: ADDR_W];
        if (!af_full) begin
          af_wr_en            = 1'b1;
          cl_req_ready[grant] = 1'b1;
          if (grant_is_read) begin
            tag_push   = 1'b1;
            adv_rr     = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = WDATA;
          end
        end
      end
      WDATA: begin
        cl_wdf_ready[grant] = !wdf_full;
        wdf_wr_en           = cl_wdf_valid[grant] & !wdf_full;
        wdf_din             = cl_wdf_din[DATA_W*int'(grant) +: DATA_W];
        wdf_mask_din        = cl_wdf_mask[MASK_W*int'(grant) +: MASK_W];
        if (wdf_wr_en && wbeat == BEAT_LAST) begin
          adv_rr     = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Read return: only the client owning the oldest tag sees or pops the rdf head.
  always_comb begin
    cl_rdf_valid       = '0;
    cl_rdf_valid[head] = rdf_valid & !tag_empty;
    rdf_rd_en          = cl_rdf_rd_en[head] & rdf_valid & !tag_empty;
  end

  assign tag_pop = rdf_rd_en & (rbeat == BEAT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      rr_ptr     <= '0;
      wbeat      <= 1'b0;
      rbeat      <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && found) grant <= pick;
      if (adv_rr && !rr_hold)     rr_ptr <= next_rr;
      if (wdf_wr_en)              wbeat <= ~wbeat;
      if (rdf_rd_en)              rbeat <= ~rbeat;
      if (rdf_valid && tag_empty) err_orphan <= 1'b1;
    end
  end
endmodule
